// File: rtl/uart_frame_tx.sv
// uart_frame_tx: multi-byte UART transmitter with start/done handshake,
// runtime length, abort, and configurable parity and stop bits.
module uart_frame_tx #(
  parameter  int CLK_FRE   = 50000000,
  parameter  int CLK_UART  = 115200,
  parameter  int NUM_BYTES = 144,
  parameter  int PARITY    = 0,
  parameter  int STOP_BITS = 1,
  localparam int LW        = $clog2(NUM_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_BYTES*8-1:0] data_in,
  input  logic [LW-1:0]          len,
  input  logic                   abort,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic [LW-1:0]          byte_idx
);

  localparam int BAUD_DIV = CLK_FRE / CLK_UART;
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic PAR_INV = (PARITY == 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          baud_cnt, baud_cnt_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [LW-1:0]          byte_cnt, byte_cnt_n, byte_idx_n;
  logic [NUM_BYTES*8-1:0] buffer, buffer_n;
  logic                   zero_pend, zero_pend_n;
  logic                   tx_n, done_n;
  logic                   tick;
  logic [7:0]             cur_byte;

  assign tick     = (baud_cnt == CW'(BAUD_DIV - 1));
  assign cur_byte = buffer[7:0];

  // tx_n is the line level for the state being entered, so tx stays registered
  always_comb begin
    state_n     = state;
    baud_cnt_n  = '0;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    byte_idx_n  = byte_idx;
    buffer_n    = buffer;
    zero_pend_n = 1'b0;
    tx_n        = tx;
    done_n      = zero_pend;

    if (state == IDLE) begin
      tx_n       = 1'b1;
      byte_idx_n = '0;
      bit_cnt_n  = '0;
      if (start && !abort) begin
        if (len == '0) begin
          zero_pend_n = 1'b1;
        end else begin
          state_n    = START;
          tx_n       = 1'b0;
          buffer_n   = data_in;
          byte_cnt_n = (len > MAX_LEN) ? MAX_LEN : len;
        end
      end
    end else if (abort) begin
      state_n    = IDLE;
      tx_n       = 1'b1;
      byte_idx_n = '0;
      bit_cnt_n  = '0;
    end else if (!tick) begin
      baud_cnt_n = baud_cnt + CW'(1);
    end else begin
      case (state)
        START: begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = cur_byte[0];
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              tx_n    = (^cur_byte) ^ PAR_INV;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = cur_byte[bit_cnt + 3'd1];
          end
        end
        PAR: begin
          state_n   = STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
        STOP: begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_cnt_n = '0;
            if ((byte_idx + LW'(1)) < byte_cnt) begin
              state_n    = START;
              byte_idx_n = byte_idx + LW'(1);
              buffer_n   = buffer >> 8;
              tx_n       = 1'b0;
            end else begin
              state_n    = IDLE;
              byte_idx_n = '0;
              tx_n       = 1'b1;
              done_n     = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_idx  <= '0;
      buffer    <= '0;
      zero_pend <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_cnt   <= bit_cnt_n;
      byte_cnt  <= byte_cnt_n;
      byte_idx  <= byte_idx_n;
      buffer    <= buffer_n;
      zero_pend <= zero_pend_n;
      tx        <= tx_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed stimulus with a frame/done scoreboard watching
// three uart_frame_tx configurations (none/1 stop, even/2 stop, odd/2 stop).
module tb_uart_frame_tx;

  localparam int CLK_FRE   = 1000000;
  localparam int CLK_UART  = 100000;
  localparam int NUM_BYTES = 4;
  localparam int BD        = 10;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         start_cyc;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [2:0]  len = '0;
  logic        abort = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  logic [2:0]  idx0, idx1, idx2;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          sel = 0;
  frame_t      exp_q[$];
  int          exp_done_q[$];

  logic        m_tx, m_busy, m_done;
  logic [2:0]  m_idx;
  int          m_par, m_stop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_tx   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : tx2;
  assign m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign m_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign m_idx  = (sel == 0) ? idx0  : (sel == 1) ? idx1  : idx2;
  assign m_par  = (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
  assign m_stop = (sel == 0) ? 1 : 2;

  uart_frame_tx #(.CLK_FRE(CLK_FRE), .CLK_UART(CLK_UART), .NUM_BYTES(NUM_BYTES),
                  .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data_in), .len(len), .abort(abort),
    .tx(tx0), .busy(busy0), .done(done0), .byte_idx(idx0));

  uart_frame_tx #(.CLK_FRE(CLK_FRE), .CLK_UART(CLK_UART), .NUM_BYTES(NUM_BYTES),
                  .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in), .len(len), .abort(abort),
    .tx(tx1), .busy(busy1), .done(done1), .byte_idx(idx1));

  uart_frame_tx #(.CLK_FRE(CLK_FRE), .CLK_UART(CLK_UART), .NUM_BYTES(NUM_BYTES),
                  .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data_in), .len(len), .abort(abort),
    .tx(tx2), .busy(busy2), .done(done2), .byte_idx(idx2));

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic apply_stimulus(input int inst, input logic [31:0] d, input logic [2:0] l,
                                output int k);
    @(negedge clk);
    sel     = inst;
    data_in = d;
    len     = l;
    set_start(inst, 1'b1);
    k = cyc + 1;
  endtask

  task automatic end_stimulus(input int inst);
    @(negedge clk);
    set_start(inst, 1'b0);
  endtask

  task automatic push_frame(input int at, input logic [7:0] d, input logic p);
    frame_t f;
    f.data = d;
    f.par = p;
    f.start_cyc = at;
    exp_q.push_back(f);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("scoreboard_drain_pending", exp_q.size() + exp_done_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  // Frame monitor: rebuilds each serial frame and compares against the queue
  initial begin : frame_mon
    logic       prev_tx, first, sb, pb, stop_ok, stable, trunc;
    logic [7:0] data;
    int         nbits, start_c;
    frame_t     e;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_tx === 1'b1 && m_tx === 1'b0) begin
        check_output("start_bit_busy", 32'(m_busy), 1);
        start_c = cyc;
        nbits   = 9 + ((m_par != 0) ? 1 : 0) + m_stop;
        trunc   = (m_busy !== 1'b1);
        stable  = 1'b1;
        stop_ok = 1'b1;
        sb      = 1'b1;
        pb      = 1'b0;
        data    = '0;
        first   = 1'b0;
        for (int b = 0; b < nbits && !trunc; b++) begin
          for (int c = 0; c < BD; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (m_busy !== 1'b1) begin
              trunc = 1'b1;
              break;
            end
            if (c == 0) first = m_tx;
            else if (m_tx !== first) stable = 1'b0;
          end
          if (b == 0) sb = first;
          else if (b <= 8) data = {first, data[7:1]};
          else if (b == 9 && m_par != 0) pb = first;
          else stop_ok = stop_ok & first;
        end
        if (!trunc) begin
          if (exp_q.size() == 0) begin
            check_output("frame_expected_pending", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check_output("frame_start_cycle", start_c, e.start_cyc);
            check_output("frame_start_bit", 32'(sb), 0);
            check_output("frame_data", 32'(data), 32'(e.data));
            if (m_par != 0) check_output("frame_parity", 32'(pb), 32'(e.par));
            check_output("frame_stop_bits", 32'(stop_ok), 1);
            check_output("frame_bit_width", 32'(stable), 1);
          end
        end
      end
      prev_tx = m_tx;
    end
  end

  // Done monitor: each done pulse must match a queued completion cycle
  initial begin : done_mon
    int e;
    forever begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          check_output("done_expected_pending", 0, 1);
        end else begin
          e = exp_done_q.pop_front();
          check_output("done_cycle", cyc, e);
          check_output("done_busy", 32'(m_busy), 0);
          check_output("done_tx", 32'(m_tx), 1);
          check_output("done_byte_idx", 32'(m_idx), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    int k;
    int bad;
    repeat (3) @(negedge clk);
    check_output("reset_tx", 32'(tx0), 1);
    check_output("reset_busy", 32'(busy0), 0);
    check_output("reset_done", 32'(done0), 0);
    check_output("reset_byte_idx", 32'(idx0), 0);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
    end
    check_output("idle_100_cycles_bad", bad, 0);

    $display("[TB] basic two-byte transfer");
    apply_stimulus(0, 32'h0000A555, 3'd2, k);
    push_frame(k, 8'h55, 1'b0);
    push_frame(k + 100, 8'hA5, 1'b0);
    exp_done_q.push_back(k + 200);
    end_stimulus(0);
    wait_until(k + 150);
    check_output("basic_byte_idx_mid", 32'(idx0), 1);
    drain(400);

    $display("[TB] even parity, two stop bits");
    apply_stimulus(1, 32'h00000007, 3'd1, k);
    push_frame(k, 8'h07, 1'b1);
    exp_done_q.push_back(k + 120);
    end_stimulus(1);
    drain(300);

    $display("[TB] odd parity, two stop bits");
    apply_stimulus(2, 32'h00000007, 3'd1, k);
    push_frame(k, 8'h07, 1'b0);
    exp_done_q.push_back(k + 120);
    end_stimulus(2);
    drain(300);

    $display("[TB] zero length");
    apply_stimulus(0, 32'h000000FF, 3'd0, k);
    exp_done_q.push_back(k + 1);
    end_stimulus(0);
    check_output("len0_busy", 32'(busy0), 0);
    drain(50);

    $display("[TB] length clamp");
    apply_stimulus(0, 32'h12345678, 3'd7, k);
    push_frame(k, 8'h78, 1'b0);
    push_frame(k + 100, 8'h56, 1'b0);
    push_frame(k + 200, 8'h34, 1'b0);
    push_frame(k + 300, 8'h12, 1'b0);
    exp_done_q.push_back(k + 400);
    end_stimulus(0);
    wait_until(k + 250);
    check_output("clamp_byte_idx_mid", 32'(idx0), 2);
    drain(800);

    $display("[TB] abort mid-frame");
    apply_stimulus(0, 32'h0000000F, 3'd1, k);
    end_stimulus(0);
    wait_until(k + 55);
    check_output("abort_pre_tx", 32'(tx0), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_tx", 32'(tx0), 1);
    check_output("abort_busy", 32'(busy0), 0);
    check_output("abort_byte_idx", 32'(idx0), 0);
    repeat (150) @(negedge clk);

    $display("[TB] abort on final stop expiry");
    apply_stimulus(0, 32'h0000003C, 3'd1, k);
    push_frame(k, 8'h3C, 1'b0);
    end_stimulus(0);
    wait_until(k + 99);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_last_done", 32'(done0), 0);
    check_output("abort_last_busy", 32'(busy0), 0);
    drain(100);
    repeat (20) @(negedge clk);

    $display("[TB] start with abort while idle");
    @(negedge clk);
    len = 3'd1;
    start0 = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort = 1'b0;
    check_output("start_abort_busy", 32'(busy0), 0);
    check_output("start_abort_tx", 32'(tx0), 1);
    repeat (20) @(negedge clk);

    $display("[TB] busy protection");
    apply_stimulus(0, 32'h00000033, 3'd1, k);
    push_frame(k, 8'h33, 1'b0);
    exp_done_q.push_back(k + 100);
    end_stimulus(0);
    wait_until(k + 30);
    data_in = 32'hFFFFFFFF;
    len = 3'd3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain(300);

    $display("[TB] back-to-back with start held");
    apply_stimulus(0, 32'h0000005A, 3'd1, k);
    push_frame(k, 8'h5A, 1'b0);
    exp_done_q.push_back(k + 100);
    push_frame(k + 101, 8'h5A, 1'b0);
    exp_done_q.push_back(k + 201);
    wait_until(k + 101);
    start0 = 1'b0;
    drain(400);

    $display("[TB] mid-frame reset");
    apply_stimulus(0, 32'h0000000F, 3'd1, k);
    end_stimulus(0);
    wait_until(k + 73);
    check_output("reset_pre_tx", 32'(tx0), 0);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_tx", 32'(tx0), 1);
    check_output("async_reset_busy", 32'(busy0), 0);
    check_output("async_reset_byte_idx", 32'(idx0), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_output("post_reset_tx", 32'(tx0), 1);
    check_output("post_reset_busy", 32'(busy0), 0);
    check_output("final_queues_empty", exp_q.size() + exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
